cpc_mem_arbiter: RTL

- Shares the single external memory port between three requesters: video fetch (CRTC/gate-array vram reads), Z80 memory cycles, and the ROM/disk image loader.
- Sits between the motherboard memory signals and the SDRAM controller.
- Video has fixed top priority so the 16-bit vram word always arrives before the gate array shifts it.
- Serialises requests to one outstanding transaction and reports missed video deadlines.

---
 rtl/cpc_mem_arbiter_if.sv | 50 +++++
 rtl/cpc_mem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpc_mem_arbiter_if.sv
// Bus bundle for the CPC memory arbiter: video, CPU and loader
// request ports plus the external memory port.
// slave  : arbiter view (requests in, memory request out)
// master : environment view (requesters and memory controller)
interface cpc_mem_arbiter_if #(
  parameter int ADDR_W = 23
);
  logic              vid_req;
  logic [14:0]       vid_addr;
  logic [15:0]       vid_data;
  logic              vid_valid;
  logic              vid_late;
  logic              vid_late_clr;
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_din;
  logic [7:0]        cpu_dout;
  logic              cpu_ready;
  logic              ld_wr;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_data;
  logic              ld_busy;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic [15:0]       mem_rdata;

  modport slave (
    input  vid_req, vid_addr, vid_late_clr,
    input  cpu_rd, cpu_wr, cpu_addr, cpu_din,
    input  ld_wr, ld_addr, ld_data,
    input  mem_ack, mem_rdata,
    output vid_data, vid_valid, vid_late,
    output cpu_dout, cpu_ready, ld_busy,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output vid_req, vid_addr, vid_late_clr,
    output cpu_rd, cpu_wr, cpu_addr, cpu_din,
    output ld_wr, ld_addr, ld_data,
    output mem_ack, mem_rdata,
    input  vid_data, vid_valid, vid_late,
    input  cpu_dout, cpu_ready, ld_busy,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cpc_mem_arbiter.sv
// CPC memory arbiter: shares one SDRAM port between video fetch,
// Z80 cycles and the image loader, one transaction at a time.
// Ports: clk, reset_n (async active-low), bus (cpc_mem_arbiter_if.slave)
//   video : vid_req/vid_addr -> vid_data/vid_valid, vid_late(+clr)
//   cpu   : cpu_rd/cpu_wr/cpu_addr/cpu_din -> cpu_dout/cpu_ready
//   loader: ld_wr/ld_addr/ld_data -> ld_busy
//   memory: mem_req/mem_we/mem_addr/mem_wdata, mem_ack/mem_rdata
module cpc_mem_arbiter #(
  parameter int                VID_DEADLINE = 12,
  parameter int                ADDR_W       = 23,
  parameter logic [ADDR_W-1:0] VID_BASE     = '0
) (
  input logic              clk,
  input logic              reset_n,
  cpc_mem_arbiter_if.slave bus
);
  localparam int            CW = $clog2(VID_DEADLINE + 1);
  localparam logic [CW-1:0] DL = CW'(VID_DEADLINE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_VID,
    S_CPU,
    S_LD
  } state_t;

  state_t state_q, state_d;

  logic              vid_pend_q, vid_pend_d;
  logic [14:0]       vid_addr_q, vid_addr_d;
  logic              cpu_pend_q, cpu_pend_d;
  logic              cpu_abort_q, cpu_abort_d;
  logic              cpu_we_q, cpu_we_d;
  logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
  logic [7:0]        cpu_din_q, cpu_din_d;
  logic              cpu_act_q;
  logic              ld_pend_q, ld_pend_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic [7:0]        ld_data_q, ld_data_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              vid_late_q, vid_late_d;
  logic              vid_valid_q, vid_valid_d;
  logic [15:0]       vid_data_q, vid_data_d;
  logic [7:0]        cpu_dout_q, cpu_dout_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;

  logic cpu_act;
  logic cpu_rise;
  logic ack_vid;
  logic ack_cpu;
  logic ack_ld;
  logic late_set;

  assign cpu_act  = bus.cpu_rd | bus.cpu_wr;
  assign cpu_rise = cpu_act & ~cpu_act_q;
  assign ack_vid  = (state_q == S_VID) & bus.mem_ack;
  assign ack_cpu  = (state_q == S_CPU) & bus.mem_ack;
  assign ack_ld   = (state_q == S_LD) & bus.mem_ack;

  // Request capture
  always_comb begin
    vid_pend_d  = vid_pend_q;
    vid_addr_d  = vid_addr_q;
    cpu_pend_d  = cpu_pend_q;
    cpu_abort_d = cpu_abort_q;
    cpu_we_d    = cpu_we_q;
    cpu_addr_d  = cpu_addr_q;
    cpu_din_d   = cpu_din_q;
    ld_pend_d   = ld_pend_q;
    ld_addr_d   = ld_addr_q;
    ld_data_d   = ld_data_q;

    if (ack_vid) vid_pend_d = 1'b0;
    if (bus.vid_req && !vid_pend_q) begin
      vid_pend_d = 1'b1;
      vid_addr_d = bus.vid_addr;
    end

    // A CPU that lets go mid-transaction still gets its cycle
    // run to completion; only the read result is thrown away.
    if (ack_cpu) begin
      cpu_pend_d  = 1'b0;
      cpu_abort_d = 1'b0;
    end else if (cpu_pend_q && !cpu_act) begin
      cpu_abort_d = 1'b1;
    end
    if (cpu_rise && !cpu_pend_q) begin
      cpu_pend_d  = 1'b1;
      cpu_abort_d = 1'b0;
      cpu_we_d    = bus.cpu_wr;
      cpu_addr_d  = bus.cpu_addr;
      cpu_din_d   = bus.cpu_din;
    end

    if (ack_ld) ld_pend_d = 1'b0;
    if (bus.ld_wr && !ld_pend_q) begin
      ld_pend_d = 1'b1;
      ld_addr_d = bus.ld_addr;
      ld_data_d = bus.ld_data;
    end
  end

  // Video deadline watch; a set beats a clear in the same cycle
  always_comb begin
    cnt_d    = cnt_q;
    late_set = bus.vid_req & vid_pend_q;
    if (bus.vid_req) begin
      cnt_d = '0;
    end else if (vid_pend_q && cnt_q != DL) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == DL) late_set = 1'b1;
    end
    vid_late_d = vid_late_q;
    if (bus.vid_late_clr) vid_late_d = 1'b0;
    if (late_set) vid_late_d = 1'b1;
  end

  // Grant FSM and memory request registers
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (vid_pend_q) begin
          state_d     = S_VID;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = VID_BASE + ADDR_W'({vid_addr_q, 1'b0});
          mem_wdata_d = 8'h00;
        end else if (cpu_pend_q) begin
          state_d     = S_CPU;
          mem_req_d   = 1'b1;
          mem_we_d    = cpu_we_q;
          mem_addr_d  = cpu_addr_q;
          mem_wdata_d = cpu_din_q;
        end else if (ld_pend_q) begin
          state_d     = S_LD;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = ld_addr_q;
          mem_wdata_d = ld_data_q;
        end
      end
      default: begin
        if (bus.mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
        end
      end
    endcase
  end

  // Completion outputs
  always_comb begin
    vid_valid_d = ack_vid;
    vid_data_d  = vid_data_q;
    cpu_dout_d  = cpu_dout_q;
    if (ack_vid) vid_data_d = bus.mem_rdata;
    if (ack_cpu && !cpu_we_q && !cpu_abort_q && cpu_act) begin
      cpu_dout_d = cpu_addr_q[0] ? bus.mem_rdata[15:8]
                                 : bus.mem_rdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      vid_pend_q  <= 1'b0;
      vid_addr_q  <= '0;
      cpu_pend_q  <= 1'b0;
      cpu_abort_q <= 1'b0;
      cpu_we_q    <= 1'b0;
      cpu_addr_q  <= '0;
      cpu_din_q   <= '0;
      cpu_act_q   <= 1'b0;
      ld_pend_q   <= 1'b0;
      ld_addr_q   <= '0;
      ld_data_q   <= '0;
      cnt_q       <= '0;
      vid_late_q  <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= '0;
      cpu_dout_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      vid_pend_q  <= vid_pend_d;
      vid_addr_q  <= vid_addr_d;
      cpu_pend_q  <= cpu_pend_d;
      cpu_abort_q <= cpu_abort_d;
      cpu_we_q    <= cpu_we_d;
      cpu_addr_q  <= cpu_addr_d;
      cpu_din_q   <= cpu_din_d;
      cpu_act_q   <= cpu_act;
      ld_pend_q   <= ld_pend_d;
      ld_addr_q   <= ld_addr_d;
      ld_data_q   <= ld_data_d;
      cnt_q       <= cnt_d;
      vid_late_q  <= vid_late_d;
      vid_valid_q <= vid_valid_d;
      vid_data_q  <= vid_data_d;
      cpu_dout_q  <= cpu_dout_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.vid_data  = vid_data_q;
  assign bus.vid_valid = vid_valid_q;
  assign bus.vid_late  = vid_late_q;
  assign bus.cpu_dout  = cpu_dout_q;
  // Drops on the request edge itself so the Z80 sees WAIT in time
  assign bus.cpu_ready = ~(cpu_pend_q | cpu_rise);
  assign bus.ld_busy   = ld_pend_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule
